spike_rate_decoder: RTL and testbench

Converts the 1-bit spike train from a LIF neuron back into numeric form: an 8-bit spike count per programmable window plus the most recent inter-spike interval (ISI). It sits downstream of a neuron's `spike` output and hands results to the host-side logic over a valid/ready handshake. It is the rate decoder matching the neuron's current-to-spike encoding.

---
 rtl/snn_pkg.sv | 23 ++
 rtl/sat_counter.sv | 32 +++
 rtl/spike_rate_decoder.sv | 123 ++++++++++++
 tb/tb_spike_rate_decoder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-neural-network block family.
//
// Contents:
//   SNN_CNT_W        default width of spike counts, intervals and windows
//   decoder_state_t  rate-decoder control state (IDLE, COUNT)
//   sat_inc()        saturating increment, shared by counters in lif-family blocks
package snn_pkg;

  localparam int SNN_CNT_W = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } decoder_state_t;

  // Width-agnostic saturating increment: callers widen their operand to 32 bits,
  // pass their own ceiling, and cast the result back to their width.
  function automatic int unsigned sat_inc(input int unsigned value,
                                          input int unsigned max_value);
    return (value >= max_value) ? max_value : value + 1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//
// Ports:
//   clk    clock
//   rst_n  synchronous active-low reset
//   clr    clear to 0 (wins over inc)
//   inc    increment by one, holding at all-ones
//   count  current value
module sat_counter
  import snn_pkg::*;
#(
  parameter int W = SNN_CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam int unsigned MAX = (1 << W) - 1;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values; reset is tested inside the clocked block, which
  // makes it synchronous.
  always_ff @(posedge clk) begin
    if (!rst_n)   count <= '0;
    else if (clr) count <= '0;
    else if (inc) count <= W'(sat_inc(32'(count), MAX));
  end

endmodule

// File: rtl/spike_rate_decoder.sv
// Spike-rate decoder: turns a 1-bit spike train into a per-window spike count
// and the most recent inter-spike interval, delivered over valid/ready.
//
// Ports:
//   clk        clock
//   rst_n      synchronous active-low reset
//   enable     run decoding; low aborts the current window
//   spike      spike input, sampled every rising edge
//   window     window length in cycles (0 means 2**CNT_W), sampled at window start
//   rate       spike count of the last completed window (saturating)
//   isi        last inter-spike interval at window close
//   out_valid  rate/isi hold an unconsumed result
//   out_ready  consumer accepts the result
//   overrun    sticky: an unconsumed result was overwritten
module spike_rate_decoder
  import snn_pkg::*;
#(
  parameter int CNT_W = SNN_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             spike,
  input  logic [CNT_W-1:0] window,
  output logic [CNT_W-1:0] rate,
  output logic [CNT_W-1:0] isi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun
);

  localparam int unsigned      CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [CNT_W:0]   WIN_MAX = {1'b1, {CNT_W{1'b0}}};
  localparam logic [CNT_W:0]   WIN_ONE = {{CNT_W{1'b0}}, 1'b1};

  decoder_state_t   state;
  logic [CNT_W:0]   win_left;   // one extra bit so a full 2**CNT_W window fits
  logic [CNT_W-1:0] spk_cnt;
  logic [CNT_W-1:0] gap;
  logic             seen;
  logic [CNT_W-1:0] isi_last;

  logic             start;
  logic             counting;
  logic             abort;
  logic             close;
  logic [CNT_W:0]   win_len;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] isi_next;

  assign start    = (state == IDLE)  &&  enable;
  assign counting = (state == COUNT) &&  enable;
  assign abort    = (state == COUNT) && !enable;
  // Close on the edge that takes win_left to zero; that edge's spike still counts.
  assign close    = counting && (win_left == WIN_ONE);
  assign win_len  = (window == '0) ? WIN_MAX : {1'b0, window};

  // Count and interval as they stand after this edge's sample, so a close
  // reports the window including its final spike.
  assign cnt_next = spike ? CNT_W'(sat_inc(32'(spk_cnt), CNT_MAX)) : spk_cnt;
  assign isi_next = (counting && spike && seen) ? CNT_W'(sat_inc(32'(gap), CNT_MAX))
                                                : isi_last;

  sat_counter #(.W(CNT_W)) u_spk_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start || close || abort),
    .inc   (counting && spike),
    .count (spk_cnt)
  );

  // Edges since the last spike; restarts on every spike.
  sat_counter #(.W(CNT_W)) u_gap (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start || abort || (counting && spike)),
    .inc   (counting && !spike),
    .count (gap)
  );

  // Control state, window timer and interval tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      win_left <= '0;
      seen     <= 1'b0;
      isi_last <= '0;
    end else if (start) begin
      state    <= COUNT;
      win_left <= win_len;
    end else if (abort) begin
      state    <= IDLE;
      win_left <= '0;
      seen     <= 1'b0;
      isi_last <= '0;
    end else if (counting) begin
      win_left <= close ? win_len : win_left - 1'b1;
      if (spike) begin
        seen     <= 1'b1;
        isi_last <= isi_next;
      end
    end
  end

  // Result register and handshake. A close always loads a fresh result; it
  // only flags overrun when the old one was neither consumed nor being consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rate      <= '0;
      isi       <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (close) begin
      rate      <= cnt_next;
      isi       <= isi_next;
      out_valid <= 1'b1;
      if (out_valid && !out_ready) overrun <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Self-checking bench for spike_rate_decoder. Expected results are pushed to a
// scoreboard queue at each modelled window close and popped when the DUT
// hands a result over (out_valid && out_ready seen on the falling edge).
module tb_spike_rate_decoder;

  typedef struct {
    int rate;
    int isi;
  } result_t;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       spike;
  logic [7:0] window;
  logic [7:0] rate;
  logic [7:0] isi;
  logic       out_valid;
  logic       out_ready;
  logic       overrun;

  int n_checks = 0;
  int n_pass   = 0;

  result_t sb[$];

  // Transaction-level model state: edge index inside COUNT, last spike edge.
  int m_edge;
  int m_last;
  bit m_seen;
  int m_isi;

  spike_rate_decoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .spike     (spike),
    .window    (window),
    .rate      (rate),
    .isi       (isi),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int got, input int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, want);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_edge = 0;
    m_last = 0;
    m_seen = 1'b0;
    m_isi  = 0;
  endtask

  function automatic bit hit(input int e, input int period, input int phase);
    if (period == 0 || e < phase) return 1'b0;
    return ((e - phase) % period) == 0;
  endfunction

  // IDLE -> COUNT edge; the spike sampled on this edge must not be counted.
  task automatic start_count(input int w, input bit sp0);
    window = 8'(w);
    enable = 1'b1;
    spike  = sp0;
    tick();
    model_reset();
  endtask

  // COUNT -> IDLE edge; partial window and interval history are dropped.
  task automatic abort_count();
    enable = 1'b0;
    spike  = 1'b1;
    tick();
    model_reset();
  endtask

  task automatic drive_edges(input int n, input int n_spk);
    for (int i = 0; i < n; i++) begin
      spike = (i < n_spk);
      tick();
    end
  endtask

  // One full window of len edges. Mid-window the window input is changed to
  // next_w, which must only apply from the following window.
  task automatic run_window(input int len, input int next_w, input int period,
                            input int phase, input bit ready_at_close);
    int cnt;
    cnt = 0;
    for (int i = 0; i < len; i++) begin
      m_edge++;
      spike = hit(m_edge, period, phase);
      if (i == len / 2) window = 8'(next_w);
      if (ready_at_close && i == len - 1) out_ready = 1'b1;
      if (spike) begin
        if (cnt < 255) cnt++;
        if (m_seen) m_isi = (m_edge - m_last > 255) ? 255 : m_edge - m_last;
        m_seen = 1'b1;
        m_last = m_edge;
      end
      tick();
    end
    sb.push_back('{rate: cnt, isi: m_isi});
  endtask

  // Scoreboard consumer: a transfer happens on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", out_valid, 0);
      end else begin
        result_t want;
        want = sb.pop_front();
        check("sb_rate", rate, want.rate);
        check("sb_isi", isi, want.isi);
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    enable    = 1'b0;
    spike     = 1'b0;
    window    = 8'd0;
    out_ready = 1'b0;
    model_reset();
    repeat (3) tick();
    check("rst_rate", rate, 0);
    check("rst_isi", isi, 0);
    check("rst_valid", out_valid, 0);
    check("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    tick();

    // Spike held high, window 4 then a mid-window change to 6.
    out_ready = 1'b1;
    start_count(4, 1'b1);
    run_window(4, 4, 1, 1, 1'b0);
    run_window(4, 6, 1, 1, 1'b0);
    run_window(6, 6, 1, 1, 1'b0);
    check("held_overrun", overrun, 0);
    abort_count();

    // Window 10, spike every third edge starting at edge 1.
    start_count(10, 1'b1);
    run_window(10, 10, 3, 1, 1'b0);
    run_window(10, 10, 3, 1, 1'b0);
    abort_count();

    // Window 0 means 256 edges; count saturates.
    start_count(0, 1'b0);
    run_window(256, 0, 1, 1, 1'b0);
    check("w256_overrun", overrun, 0);
    abort_count();

    // Overrun: consumer stalled across two closes.
    out_ready = 1'b0;
    start_count(2, 1'b0);
    run_window(2, 2, 3, 1, 1'b0);
    check("ovr_valid1", out_valid, 1);
    check("ovr_clear1", overrun, 0);
    check("ovr_rate1", rate, 1);
    check("ovr_isi1", isi, 0);
    run_window(2, 2, 3, 1, 1'b0);
    check("ovr_set", overrun, 1);
    check("ovr_rate2", rate, 1);
    check("ovr_isi2", isi, 3);
    while (sb.size() > 1) void'(sb.pop_front());
    // Ready rises on the close edge: transfer and new result on the same edge.
    run_window(2, 2, 3, 1, 1'b1);
    check("ovr_valid_kept", out_valid, 1);
    check("ovr_rate3", rate, 0);
    check("ovr_isi3", isi, 3);
    abort_count();
    check("ovr_sticky", overrun, 1);

    // Abort with 3 spikes counted; pending result survives until handshake.
    out_ready = 1'b0;
    start_count(4, 1'b0);
    run_window(4, 8, 1, 1, 1'b0);
    drive_edges(5, 3);
    abort_count();
    check("abort_valid", out_valid, 1);
    check("abort_rate", rate, 4);
    check("abort_isi", isi, 1);
    out_ready = 1'b1;
    start_count(8, 1'b0);
    run_window(8, 8, 3, 2, 1'b0);
    out_ready = 1'b0;

    // Reset mid-window with a result pending.
    drive_edges(3, 3);
    check("pre_rst_valid", out_valid, 1);
    rst_n  = 1'b0;
    enable = 1'b0;
    tick();
    check("mid_rst_rate", rate, 0);
    check("mid_rst_isi", isi, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_overrun", overrun, 0);
    sb.delete();
    model_reset();
    rst_n = 1'b1;
    tick();

    out_ready = 1'b1;
    start_count(4, 1'b0);
    run_window(4, 4, 1, 1, 1'b0);
    abort_count();
    tick();
    check("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
